// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential fetch address, one tracked in-flight read,
// DEPTH-entry {instr, pc} queue and redirect flush. Optional macro FETCH_BYPASS_EN.
module fetch_unit #(
   parameter int             D        = 9,
   parameter int             W        = 9,
   parameter int             DEPTH    = 4,
   parameter logic [D-1:0]   RESET_PC = '0
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           redirect_en,
   input  logic [D-1:0]   redirect_addr,
   output logic           imem_rd_en,
   output logic [D-1:0]   imem_addr,
   input  logic [W-1:0]   imem_data,
   output logic           instr_valid,
   input  logic           instr_ready,
   output logic [W-1:0]   instr,
   output logic [D-1:0]   instr_pc
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   logic [D-1:0]  fetch_pc;
   logic          inflight_vld_p1;
   logic [D-1:0]  inflight_pc_p1;
   logic [W-1:0]  q_instr [DEPTH];
   logic [D-1:0]  q_pc    [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;

   logic          head_vld;
   logic          pop;
   logic          q_pop;
   logic          push;
   logic          issue;
   logic [CW:0]   occ_next;

   assign head_vld = (count != '0);

`ifdef FETCH_BYPASS_EN
   logic byp_vld;

   // A returning word is shown directly when the queue is empty; it only
   // enters the queue if decode does not take it this cycle.
   assign byp_vld     = inflight_vld_p1 & ~head_vld & ~redirect_en;
   assign instr_valid = head_vld | byp_vld;
   assign instr       = head_vld ? q_instr[rd_ptr] : (byp_vld ? imem_data : '0);
   assign instr_pc    = head_vld ? q_pc[rd_ptr] : (byp_vld ? inflight_pc_p1 : '0);
   assign push        = inflight_vld_p1 & ~redirect_en & ~reset & ~(byp_vld & instr_ready);
`else
   assign instr_valid = head_vld;
   assign instr       = head_vld ? q_instr[rd_ptr] : '0;
   assign instr_pc    = head_vld ? q_pc[rd_ptr] : '0;
   assign push        = inflight_vld_p1 & ~redirect_en & ~reset;
`endif

   assign pop   = instr_valid & instr_ready;
   assign q_pop = pop & head_vld;

   // Occupancy after this edge without a new issue; issuing only below DEPTH
   // guarantees the next return always finds a free slot.
   assign occ_next   = (CW+1)'(count) + (CW+1)'(inflight_vld_p1) - (CW+1)'(pop);
   assign issue      = ~reset & ~redirect_en & (occ_next < (CW+1)'(DEPTH));
   assign imem_rd_en = issue;
   assign imem_addr  = fetch_pc;

   // p0 -> p1: issue stage to memory-return stage, plus queue control
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc        <= RESET_PC;
         inflight_vld_p1 <= 1'b0;
         count           <= '0;
         rd_ptr          <= '0;
         wr_ptr          <= '0;
      end else if (redirect_en) begin
         fetch_pc        <= redirect_addr;
         inflight_vld_p1 <= 1'b0;
         count           <= '0;
         rd_ptr          <= '0;
         wr_ptr          <= '0;
      end else begin
         inflight_vld_p1 <= issue;
         if (issue) fetch_pc <= fetch_pc + 1'b1;
         if (push)  wr_ptr   <= wr_ptr + 1'b1;
         if (q_pop) rd_ptr   <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(q_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (issue) inflight_pc_p1 <= fetch_pc;
      if (push) begin
         q_instr[wr_ptr] <= imem_data;
         q_pc[wr_ptr]    <= inflight_pc_p1;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle table, directed backpressure/redirect
// sequences, and randomized traffic against an in-order stream reference model.
module tb_fetch_unit;

   localparam int D     = 9;
   localparam int W     = 9;
   localparam int DEPTH = 4;

   logic         clk;
   logic         reset;
   logic         redirect_en;
   logic [D-1:0] redirect_addr;
   logic         imem_rd_en;
   logic [D-1:0] imem_addr;
   logic [W-1:0] imem_data;
   logic         instr_valid;
   logic         instr_ready;
   logic [W-1:0] instr;
   logic [D-1:0] instr_pc;

   logic         rd_en2;
   logic [D-1:0] addr2;
   logic [W-1:0] data2;
   logic         valid2;
   logic [W-1:0] instr2;
   logic [D-1:0] pc2;
   logic         ready2;
   logic         redir2;
   logic [D-1:0] raddr2;

   logic [W-1:0] mem [512];

   int n_checks = 0;
   int n_pass   = 0;

   fetch_unit #(.D(D), .W(W), .DEPTH(DEPTH), .RESET_PC(9'h000)) dut (
      .clk(clk), .reset(reset), .redirect_en(redirect_en), .redirect_addr(redirect_addr),
      .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_data(imem_data),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
   );

   fetch_unit #(.D(D), .W(W), .DEPTH(DEPTH), .RESET_PC(9'h1FE)) dut2 (
      .clk(clk), .reset(reset), .redirect_en(redir2), .redirect_addr(raddr2),
      .imem_rd_en(rd_en2), .imem_addr(addr2), .imem_data(data2),
      .instr_valid(valid2), .instr_ready(ready2), .instr(instr2), .instr_pc(pc2)
   );

   assign ready2 = 1'b1;
   assign redir2 = 1'b0;
   assign raddr2 = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      for (int a = 0; a < 512; a++) mem[a] = W'(a + 256);
   end

   // Synchronous instruction memory: garbage when not read
   always @(posedge clk) imem_data <= imem_rd_en ? mem[imem_addr] : W'($urandom);
   always @(posedge clk) data2     <= rd_en2 ? mem[addr2] : W'($urandom);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: accepted instructions form the pc stream that restarts at
   // RESET_PC / redirect target; issues follow their own stream; words owned by
   // the unit (issued, not yet accepted, not flushed) never exceed DEPTH.
   logic [D-1:0] m_exp_pc = '0;
   logic [D-1:0] m_iss_pc = '0;
   int           m_out    = 0;

   always @(negedge clk) begin
      if (instr_valid && instr_ready) begin
         chk("acc_pc", instr_pc, m_exp_pc);
         chk("acc_instr", instr, mem[m_exp_pc]);
         m_exp_pc = m_exp_pc + 1'b1;
         m_out--;
      end else if (!instr_valid) begin
         chk("idle_zero", {instr, instr_pc}, 0);
      end
      if (imem_rd_en) begin
         chk("issue_addr", imem_addr, m_iss_pc);
         m_iss_pc = m_iss_pc + 1'b1;
         m_out++;
      end
      chk("occupancy", 32'(m_out <= DEPTH), 1);
      if (reset) begin
         chk("reset_no_issue", imem_rd_en, 0);
         m_exp_pc = 9'h000;
         m_iss_pc = 9'h000;
         m_out    = 0;
      end else if (redirect_en) begin
         chk("redir_no_issue", imem_rd_en, 0);
         m_exp_pc = redirect_addr;
         m_iss_pc = redirect_addr;
         m_out    = 0;
      end
   end

   typedef struct {
      logic         rst;
      logic         rdy;
      logic         redir;
      logic [D-1:0] raddr;
      logic         e_rd;
      logic [D-1:0] e_addr;
      logic         e_vld;
      logic [D-1:0] e_pc;
   } vec_t;

   function automatic vec_t mk(int rst, int rdy, int redir, int raddr,
                               int e_rd, int e_addr, int e_vld, int e_pc);
      vec_t v;
      v.rst = 1'(rst);   v.rdy = 1'(rdy);    v.redir = 1'(redir); v.raddr = D'(raddr);
      v.e_rd = 1'(e_rd); v.e_addr = D'(e_addr); v.e_vld = 1'(e_vld); v.e_pc = D'(e_pc);
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t         tbl [14];
   logic [D-1:0] q2_pc [$];
   logic [W-1:0] q2_ins [$];
   logic [D-1:0] exp2 [4];
   logic [W-1:0] e_ins;
   int           pulses;
   int           acc;

   initial begin
      tbl[0]  = mk(1, 1, 0, 'h000,   0, 'h000, 0, 'h000);
      tbl[1]  = mk(0, 1, 0, 'h000,   1, 'h000, 0, 'h000);
      tbl[2]  = mk(0, 1, 0, 'h000,   1, 'h001, 0, 'h000);
      tbl[3]  = mk(0, 1, 0, 'h000,   1, 'h002, 1, 'h000);
      tbl[4]  = mk(0, 1, 0, 'h000,   1, 'h003, 1, 'h001);
      tbl[5]  = mk(0, 1, 1, 'h050,   0, 'h004, 1, 'h002);
      tbl[6]  = mk(0, 1, 0, 'h000,   1, 'h050, 0, 'h000);
      tbl[7]  = mk(0, 1, 0, 'h000,   1, 'h051, 0, 'h000);
      tbl[8]  = mk(0, 1, 0, 'h000,   1, 'h052, 1, 'h050);
      tbl[9]  = mk(0, 1, 0, 'h000,   1, 'h053, 1, 'h051);
      tbl[10] = mk(1, 1, 1, 'h100,   0, 'h054, 1, 'h052);
      tbl[11] = mk(0, 1, 0, 'h000,   1, 'h000, 0, 'h000);
      tbl[12] = mk(0, 1, 0, 'h000,   1, 'h001, 0, 'h000);
      tbl[13] = mk(0, 1, 0, 'h000,   1, 'h002, 1, 'h000);
      exp2[0] = 9'h1FE; exp2[1] = 9'h1FF; exp2[2] = 9'h000; exp2[3] = 9'h001;

      reset = 1'b1; instr_ready = 1'b0; redirect_en = 1'b0; redirect_addr = '0;
      repeat (3) @(posedge clk);
      #1;

      // Cycle table: reset state, first fetch latency, redirect, reset over redirect
      for (int i = 0; i < 14; i++) begin
         reset = tbl[i].rst; instr_ready = tbl[i].rdy;
         redirect_en = tbl[i].redir; redirect_addr = tbl[i].raddr;
         @(negedge clk);
         e_ins = tbl[i].e_vld ? W'(tbl[i].e_pc + 9'h100) : '0;
         chk($sformatf("tbl%0d_rd_en", i), imem_rd_en, tbl[i].e_rd);
         chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
         chk($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].e_vld);
         chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].e_pc);
         chk($sformatf("tbl%0d_instr", i), instr, e_ins);
         if (i < 10 && valid2) begin
            q2_pc.push_back(pc2);
            q2_ins.push_back(instr2);
         end
         step();
      end
      redirect_en = 1'b0;

      chk("rstpc_count", 32'(q2_pc.size() >= 4), 1);
      if (q2_pc.size() >= 4) begin
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("rstpc_pc%0d", k), q2_pc[k], exp2[k]);
            chk($sformatf("rstpc_ins%0d", k), q2_ins[k], mem[exp2[k]]);
         end
      end

      // Backpressure: issue stops at DEPTH, then a gapless stream from pc 0
      reset = 1'b1; instr_ready = 1'b0;
      step();
      reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (imem_rd_en) pulses++;
         step();
      end
      chk("bp_issue_count", pulses, DEPTH);
      instr_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk($sformatf("bp_stream%0d", i), {instr_valid, instr_pc}, {1'b1, 9'(i)});
         step();
      end

      // Redirect with pc 3..5 queued and pc 6 in flight
      reset = 1'b1; instr_ready = 1'b0;
      step();
      reset = 1'b0;
      repeat (6) step();
      instr_ready = 1'b1;
      repeat (3) step();
      instr_ready = 1'b0; redirect_en = 1'b1; redirect_addr = 9'h050;
      @(negedge clk);
      chk("redir_head_before", {instr_valid, instr_pc}, {1'b1, 9'h003});
      step();
      redirect_en = 1'b0; instr_ready = 1'b1;
      @(negedge clk);
      chk("redir_n1_valid", instr_valid, 0);
      step();
      @(negedge clk);
      chk("redir_n2_valid", instr_valid, 0);
      step();
      @(negedge clk);
      chk("redir_n3_head", {instr_valid, instr_pc}, {1'b1, 9'h050});
      step();
      @(negedge clk);
      chk("redir_n4_head", {instr_valid, instr_pc}, {1'b1, 9'h051});
      step();

      // Randomized ready, redirects and occasional reset
      acc = 0;
      for (int c = 0; c < 1500; c++) begin
         reset         = ($urandom_range(0, 199) == 0);
         redirect_en   = ($urandom_range(0, 15) == 0);
         redirect_addr = D'($urandom_range(0, 511));
         instr_ready   = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (instr_valid && instr_ready) acc++;
         step();
      end
      chk("rand_throughput", 32'(acc > 300), 1);

      reset = 1'b0; redirect_en = 1'b0; instr_ready = 1'b0;
      step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end that consumes the program counter stream and delivers instructions to decode. It owns the sequential fetch address, issues reads to the synchronous instruction memory, buffers returned words in a small queue, and presents them through a valid/ready handshake. A redirect (branch/jump target from the PC logic) flushes everything in flight and restarts fetch at the new address.

## Interface
- D, 9, instruction address width
- W, 9, instruction word width
- DEPTH, 4, instruction queue entries (power of two, >= 2)
- RESET_PC, 0, fetch address after reset
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- redirect_en  input  1  flush and restart fetch at redirect_addr
- redirect_addr  input  D  new fetch address
- imem_rd_en  output  1  instruction memory read strobe
- imem_addr  output  D  instruction memory read address
- imem_data  input  W  read data, valid exactly 1 cycle after imem_rd_en
- instr_valid  output  1  queue head holds a valid instruction
- instr_ready  input  1  decode accepts head this cycle
- instr  output  W  instruction at head; 0 when instr_valid=0
- instr_pc  output  D  address of instr; 0 when instr_valid=0

## Operation
- State: fetch_pc (D bits), 1-entry in-flight tracker (valid, pc), queue of DEPTH {instr, pc} entries with count 0..DEPTH.
- imem_addr = fetch_pc (registered). imem_rd_en = issue condition.
- Issue when: not reset, redirect_en=0, and count + inflight_valid - pop < DEPTH, where pop = instr_valid & instr_ready. On issue fetch_pc <= fetch_pc + 1, wrapping 2^D-1 -> 0.
- Return: cycle after issue, imem_data with its tracked pc is pushed to the queue unless a redirect occurred in between (then discarded).
- Transfer: instr_valid & instr_ready pops head. Push and pop in the same cycle: count unchanged, order preserved. Issue rule guarantees push never hits a full queue.
- Redirect (priority over everything): queue emptied, in-flight response discarded, fetch_pc <= redirect_addr, no issue that cycle. A handshake occurring in the redirect cycle is a completed transfer (decode owns that instruction).
- Reset: fetch_pc=RESET_PC, count=0, inflight_valid=0. Reset overrides redirect.

## Timing
- Reset values: imem_rd_en=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- Steady state with instr_ready=1: one instruction per cycle.
- Redirect asserted cycle N: imem_addr=target, imem_rd_en=1 at N+1; data returns N+2; instr_valid=1 at N+3 (N+2 with bypass).
- First fetch after reset release (reset low at cycle 0): issue cycle 0, instr_valid at cycle 2.
- Backpressure: with instr_ready=0, issue stops once count+inflight reaches DEPTH; no word dropped or duplicated.
- instr_valid, instr, instr_pc depend only on registered state (or bypass path); no combinational path from instr_ready to instr_valid.

## Configuration
- FETCH_BYPASS_EN defined: when queue is empty and a non-discarded return arrives, instr_valid=1 with instr=imem_data, instr_pc=tracked pc in that same cycle; if accepted it is not pushed, otherwise pushed. Redirect latency to valid = 2 cycles.
- Undefined: returns always enter the queue first; redirect latency to valid = 3 cycles. Functional ordering identical in both builds.

## Test plan
- Reset then instr_ready=1, memory word at addr a = a+0x100 (mod 2^W): instr_pc sequence 0,1,2,3,... one per cycle from cycle 2, instr matches.
- instr_ready=0 for 10 cycles after reset: imem_rd_en pulses exactly DEPTH=4 times; on release instrs for pc 0..3 then 4 onward, no gaps or repeats.
- Redirect to 0x050 while queue holds pc 3..5 and a read in flight: those discarded; next instr_valid (cycle N+3, or N+2 with FETCH_BYPASS_EN) carries instr_pc=0x050, then 0x051.
- RESET_PC=0x1FE, free run: instr_pc 0x1FE, 0x1FF, 0x000, 0x001.
- Redirect and reset asserted together: reset wins, fetch restarts at RESET_PC, instr_valid=0 next cycle.
- Random instr_ready and redirects against a reference model: every accepted instr_pc equals expected sequence, instr = mem[instr_pc], count never exceeds DEPTH.
